// File: rtl/audio_buffer_reader_pkg.sv
// audio_buffer_reader_pkg: shared state encoding and sample constants for the
// playback-side ping-pong buffer reader.
package audio_buffer_reader_pkg;

  localparam int         SAMPLE_BITS   = 16;
  localparam logic [7:0] MONO_CHANNELS = 8'd1;

  typedef enum logic [2:0] {
    WAIT_FILL,
    IDLE,
    FETCH,
    PRESENT,
    SWAP
  } state_t;

  // Bytes making up one frame in RAM: one 16-bit sample for mono, two for stereo.
  function automatic logic [2:0] bytes_per_frame(input logic mono);
    return mono ? 3'd2 : 3'd4;
  endfunction

endpackage

// File: rtl/audio_sample_assembler.sv
// audio_sample_assembler: captures the RAM bytes of one frame and joins them
// little-endian into left/right samples, duplicating left into right for mono.
module audio_sample_assembler
  import audio_buffer_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   capture_en,
  input  logic [1:0]             capture_idx,
  input  logic [7:0]             byte_data,
  input  logic                   mono,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample
);

  logic [7:0] frame_bytes [4];

  // Store each fetched byte in its slot: L_lo, L_hi, R_lo, R_hi.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        frame_bytes[i] <= '0;
      end
    end else if (capture_en) begin
      frame_bytes[capture_idx] <= byte_data;
    end
  end

  assign left_sample  = {frame_bytes[1], frame_bytes[0]};
  assign right_sample = mono ? left_sample : {frame_bytes[3], frame_bytes[2]};

endmodule

// File: rtl/audio_buffer_reader.sv
// audio_buffer_reader: reads 16-bit little-endian PCM from the active half of
// the ping-pong audio RAM, presents frames to the I2S serializer on request,
// and owns half selection plus the filled/empty/empty_ack writer handshake.
// Optional feature: define AUDIO_READER_UNDERRUN_CNT_EN to build the
// saturating underrun counter; otherwise underrun_count_o is tied to zero.
module audio_buffer_reader
  import audio_buffer_reader_pkg::*;
#(
  parameter int BUFFER_ADDR_BITS = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pause_i,
  input  logic                        sample_req_i,
  output logic [SAMPLE_BITS-1:0]      sample_left_o,
  output logic [SAMPLE_BITS-1:0]      sample_right_o,
  output logic                        sample_valid_o,
  output logic [BUFFER_ADDR_BITS-1:0] buffer_addr_o,
  output logic                        buffer_sel_o,
  input  logic [7:0]                  buffer_data_i,
  input  logic                        buffer_filled_i,
  output logic                        buffer_empty_o,
  input  logic                        buffer_empty_ack_i,
  input  logic [7:0]                  wav_channels_i,
  output logic [15:0]                 underrun_count_o
);

  state_t                 state;
  logic [2:0]             fetch_cnt;
  logic [2:0]             frame_bytes;
  logic                   fetch_mono;
  logic                   wrapped;
  logic                   zero_pend;
  logic                   capture_en;
  logic [1:0]             capture_idx;
  logic [SAMPLE_BITS-1:0] frame_left;
  logic [SAMPLE_BITS-1:0] frame_right;

  assign frame_bytes = bytes_per_frame(fetch_mono);
  // RAM q lags the address by one cycle, so byte k lands on fetch count k+1.
  assign capture_en  = (state == FETCH) && (fetch_cnt != 3'd0);
  assign capture_idx = fetch_cnt[1:0] - 2'd1;

  audio_sample_assembler u_assembler (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .capture_idx  (capture_idx),
    .byte_data    (buffer_data_i),
    .mono         (fetch_mono),
    .left_sample  (frame_left),
    .right_sample (frame_right)
  );

  // Main reader FSM: fetch/present frames, serve silence, swap halves, track empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= WAIT_FILL;
      fetch_cnt      <= '0;
      fetch_mono     <= 1'b0;
      wrapped        <= 1'b0;
      zero_pend      <= 1'b0;
      sample_left_o  <= '0;
      sample_right_o <= '0;
      sample_valid_o <= 1'b0;
      buffer_addr_o  <= '0;
      buffer_sel_o   <= 1'b0;
      buffer_empty_o <= 1'b0;
    end else begin
      sample_valid_o <= 1'b0;
      zero_pend      <= 1'b0;

      if (zero_pend) begin
        sample_left_o  <= '0;
        sample_right_o <= '0;
        sample_valid_o <= 1'b1;
      end

      if (buffer_empty_ack_i) begin
        buffer_empty_o <= 1'b0;
      end

      case (state)
        WAIT_FILL: begin
          if (sample_req_i) begin
            zero_pend <= 1'b1;
          end
          if (buffer_filled_i) begin
            state <= SWAP;
          end
        end

        IDLE: begin
          if (sample_req_i) begin
            if (pause_i) begin
              zero_pend <= 1'b1;
            end else begin
              state      <= FETCH;
              fetch_cnt  <= '0;
              fetch_mono <= (wav_channels_i == MONO_CHANNELS);
              wrapped    <= 1'b0;
            end
          end
        end

        FETCH: begin
          if (fetch_cnt < frame_bytes) begin
            buffer_addr_o <= buffer_addr_o + BUFFER_ADDR_BITS'(1);
            if (&buffer_addr_o) begin
              wrapped <= 1'b1;
            end
          end
          if (fetch_cnt == frame_bytes) begin
            state <= PRESENT;
          end
          fetch_cnt <= fetch_cnt + 3'd1;
        end

        PRESENT: begin
          sample_left_o  <= frame_left;
          sample_right_o <= frame_right;
          sample_valid_o <= 1'b1;
          if (!wrapped) begin
            state <= IDLE;
          end else if (buffer_filled_i) begin
            state <= SWAP;
          end else begin
            state <= WAIT_FILL;
          end
        end

        SWAP: begin
          buffer_sel_o   <= ~buffer_sel_o;
          buffer_empty_o <= 1'b1;
          buffer_addr_o  <= '0;
          state          <= IDLE;
        end

        default: begin
          state <= WAIT_FILL;
        end
      endcase
    end
  end

`ifdef AUDIO_READER_UNDERRUN_CNT_EN
  logic seen_fill;
  logic underrun_pend;

  // Count silence frames served while starved, ignoring the start-up wait before the first fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_fill        <= 1'b0;
      underrun_pend    <= 1'b0;
      underrun_count_o <= '0;
    end else begin
      if (state == SWAP) begin
        seen_fill <= 1'b1;
      end
      underrun_pend <= (state == WAIT_FILL) && sample_req_i && seen_fill;
      if (underrun_pend && (underrun_count_o != 16'hFFFF)) begin
        underrun_count_o <= underrun_count_o + 16'd1;
      end
    end
  end
`else
  assign underrun_count_o = '0;
`endif

endmodule

// File: tb/tb_audio_buffer_reader.sv
// tb_audio_buffer_reader: directed-plus-random bench for audio_buffer_reader.
// A byte-array RAM model feeds the DUT; expected frames are read straight out
// of that array with a read pointer and half index kept by the bench.
module tb_audio_buffer_reader;

  localparam int         AW      = 10;
  localparam int         HALF    = 1 << AW;
  localparam int         GAP     = 16;
  localparam logic [7:0] MONO_CH = 8'd1;

`ifdef AUDIO_READER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pause_i;
  logic          sample_req_i;
  logic [15:0]   sample_left_o;
  logic [15:0]   sample_right_o;
  logic          sample_valid_o;
  logic [AW-1:0] buffer_addr_o;
  logic          buffer_sel_o;
  logic [7:0]    buffer_data_i;
  logic          buffer_filled_i;
  logic          buffer_empty_o;
  logic          buffer_empty_ack_i;
  logic [7:0]    wav_channels_i;
  logic [15:0]   underrun_count_o;

  logic [7:0] mem [2][HALF];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ptr;
  logic exp_sel;
  logic exp_empty;
  int   exp_underruns;

  audio_buffer_reader #(.BUFFER_ADDR_BITS(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pause_i            (pause_i),
    .sample_req_i       (sample_req_i),
    .sample_left_o      (sample_left_o),
    .sample_right_o     (sample_right_o),
    .sample_valid_o     (sample_valid_o),
    .buffer_addr_o      (buffer_addr_o),
    .buffer_sel_o       (buffer_sel_o),
    .buffer_data_i      (buffer_data_i),
    .buffer_filled_i    (buffer_filled_i),
    .buffer_empty_o     (buffer_empty_o),
    .buffer_empty_ack_i (buffer_empty_ack_i),
    .wav_channels_i     (wav_channels_i),
    .underrun_count_o   (underrun_count_o)
  );

  always #5 clk = ~clk;

  // Synchronous RAM read port: q follows the address by one clock.
  always @(posedge clk) buffer_data_i <= mem[buffer_sel_o][buffer_addr_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] rd16(input logic half, input int a);
    return {mem[half][a+1], mem[half][a]};
  endfunction

  function automatic logic [7:0] pick_stereo();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == MONO_CH) v = 8'd2;
    return v;
  endfunction

  task automatic refill(input logic half);
    for (int i = 0; i < HALF; i++) mem[half][i] = 8'($urandom);
  endtask

  // One request strobe; reports latency to the valid pulse and pulses seen afterwards.
  task automatic applyStimulus(input logic pause, input logic [7:0] chans, output int latency,
                               output logic [15:0] l, output logic [15:0] r, output int extra);
    pause_i        = pause;
    wav_channels_i = chans;
    sample_req_i   = 1'b1;
    tick();
    sample_req_i = 1'b0;
    latency = -1;
    l = 'x;
    r = 'x;
    extra = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (sample_valid_o) begin
        latency = k;
        l = sample_left_o;
        r = sample_right_o;
        break;
      end
    end
    for (int k = 0; k < GAP; k++) begin
      tick();
      if (sample_valid_o) extra++;
    end
  endtask

  task automatic doFrame(input bit mono, input string tag);
    int lat;
    int extra;
    logic [15:0] l, r, el, er;
    el = rd16(exp_sel, exp_ptr);
    er = mono ? el : rd16(exp_sel, exp_ptr + 2);
    applyStimulus(1'b0, mono ? MONO_CH : pick_stereo(), lat, l, r, extra);
    checkOutput({tag, "_latency"}, 32'(lat), mono ? 32'd4 : 32'd6);
    checkOutput({tag, "_left"}, 32'(l), 32'(el));
    checkOutput({tag, "_right"}, 32'(r), 32'(er));
    checkOutput({tag, "_extra_valid"}, 32'(extra), 32'd0);
    exp_ptr += mono ? 2 : 4;
    if (exp_ptr == HALF) begin
      exp_ptr = 0;
      if (buffer_filled_i) begin
        exp_sel   = ~exp_sel;
        exp_empty = 1'b1;
      end
    end
    checkOutput({tag, "_addr"}, 32'(buffer_addr_o), 32'(exp_ptr));
    checkOutput({tag, "_sel"}, 32'(buffer_sel_o), 32'(exp_sel));
    checkOutput({tag, "_empty"}, 32'(buffer_empty_o), 32'(exp_empty));
  endtask

  task automatic doZero(input logic pause, input bit underrun, input string tag);
    int lat;
    int extra;
    logic [15:0] l, r;
    applyStimulus(pause, pick_stereo(), lat, l, r, extra);
    if (underrun) exp_underruns++;
    checkOutput({tag, "_latency"}, 32'(lat), 32'd1);
    checkOutput({tag, "_left"}, 32'(l), 32'd0);
    checkOutput({tag, "_right"}, 32'(r), 32'd0);
    checkOutput({tag, "_extra_valid"}, 32'(extra), 32'd0);
    checkOutput({tag, "_addr"}, 32'(buffer_addr_o), 32'(exp_ptr));
    checkOutput({tag, "_underruns"}, 32'(underrun_count_o), CNT_EN ? 32'(exp_underruns) : 32'd0);
  endtask

  task automatic waitSwap(input string tag);
    int k = 0;
    while (buffer_sel_o !== exp_sel && k < 10) begin
      tick();
      k++;
    end
    checkOutput({tag, "_sel"}, 32'(buffer_sel_o), 32'(exp_sel));
    checkOutput({tag, "_addr"}, 32'(buffer_addr_o), 32'd0);
    checkOutput({tag, "_empty"}, 32'(buffer_empty_o), 32'd1);
  endtask

  task automatic ackEmpty(input string tag);
    buffer_empty_ack_i = 1'b1;
    tick();
    buffer_empty_ack_i = 1'b0;
    exp_empty = 1'b0;
    checkOutput({tag, "_empty_cleared"}, 32'(buffer_empty_o), 32'd0);
  endtask

  initial begin
    int pulses;
    int choice;
    rst_n              = 1'b0;
    pause_i            = 1'b0;
    sample_req_i       = 1'b0;
    buffer_filled_i    = 1'b0;
    buffer_empty_ack_i = 1'b0;
    wav_channels_i     = 8'd2;
    refill(1'b0);
    refill(1'b1);
    mem[1][0] = 8'h34; mem[1][1] = 8'h12; mem[1][2] = 8'h78; mem[1][3] = 8'h56;
    mem[1][4] = 8'hCD; mem[1][5] = 8'hAB;
    exp_ptr = 0; exp_sel = 1'b0; exp_empty = 1'b0; exp_underruns = 0;

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst_valid", 32'(sample_valid_o), 32'd0);
    checkOutput("rst_left", 32'(sample_left_o), 32'd0);
    checkOutput("rst_right", 32'(sample_right_o), 32'd0);
    checkOutput("rst_addr", 32'(buffer_addr_o), 32'd0);
    checkOutput("rst_sel", 32'(buffer_sel_o), 32'd0);
    checkOutput("rst_empty", 32'(buffer_empty_o), 32'd0);
    checkOutput("rst_underruns", 32'(underrun_count_o), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] request before first fill");
    doZero(1'b0, 1'b0, "prefill");

    $display("[TB] first fill and swap");
    buffer_filled_i = 1'b1;
    exp_sel = 1'b1;
    exp_empty = 1'b1;
    waitSwap("swap1");
    ackEmpty("swap1");

    $display("[TB] directed stereo and mono frames");
    doFrame(1'b0, "stereo_1234_5678");
    checkOutput("stereo_direct_left", 32'(sample_left_o), 32'h1234);
    checkOutput("stereo_direct_right", 32'(sample_right_o), 32'h5678);
    doFrame(1'b1, "mono_abcd");
    checkOutput("mono_direct_left", 32'(sample_left_o), 32'hABCD);
    checkOutput("mono_direct_right", 32'(sample_right_o), 32'hABCD);
    doFrame(1'b1, "mono_align");

    $display("[TB] random frames to the end of half 1");
    do begin
      choice = int'($urandom_range(0, 7));
      if (choice == 0) begin
        doZero(1'b1, 1'b0, "rand_pause");
      end else if (choice <= 2) begin
        doFrame(1'b1, "rand_mono_a");
        doFrame(1'b1, "rand_mono_b");
      end else begin
        doFrame(1'b0, "rand_stereo");
      end
    end while (exp_ptr != 0);
    checkOutput("wrap1_sel", 32'(buffer_sel_o), 32'd0);
    checkOutput("wrap1_empty", 32'(buffer_empty_o), 32'd1);
    ackEmpty("wrap1");

    $display("[TB] drain half 0 with no fill pending");
    buffer_filled_i = 1'b0;
    do begin
      doFrame(1'b0, "drain_stereo");
    end while (exp_ptr != 0);
    checkOutput("starve_sel", 32'(buffer_sel_o), 32'd0);

    $display("[TB] underrun frames");
    doZero(1'b0, 1'b1, "underrun_1");
    doZero(1'b0, 1'b1, "underrun_2");
    doZero(1'b0, 1'b1, "underrun_3");

    $display("[TB] refill resumes on the other half");
    refill(1'b1);
    buffer_filled_i = 1'b1;
    exp_sel = 1'b1;
    exp_empty = 1'b1;
    waitSwap("swap3");
    ackEmpty("swap3");
    doFrame(1'b0, "resume_stereo");
    doFrame(1'b0, "pre_pause_a");
    doFrame(1'b1, "pre_pause_b");
    doFrame(1'b1, "pre_pause_c");

    $display("[TB] pause holds the address");
    for (int i = 0; i < 4; i++) doZero(1'b1, 1'b0, "pause");
    doFrame(1'b0, "post_pause");

    $display("[TB] reset during fetch");
    pause_i = 1'b0;
    wav_channels_i = 8'd2;
    sample_req_i = 1'b1;
    tick();
    sample_req_i = 1'b0;
    tick();
    tick();
    buffer_filled_i = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_valid", 32'(sample_valid_o), 32'd0);
    checkOutput("midrst_left", 32'(sample_left_o), 32'd0);
    checkOutput("midrst_right", 32'(sample_right_o), 32'd0);
    checkOutput("midrst_addr", 32'(buffer_addr_o), 32'd0);
    checkOutput("midrst_sel", 32'(buffer_sel_o), 32'd0);
    checkOutput("midrst_empty", 32'(buffer_empty_o), 32'd0);
    checkOutput("midrst_underruns", 32'(underrun_count_o), 32'd0);
    pulses = 0;
    repeat (3) begin
      tick();
      if (sample_valid_o) pulses++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (sample_valid_o) pulses++;
    end
    checkOutput("midrst_no_valid", 32'(pulses), 32'd0);
    exp_ptr = 0; exp_sel = 1'b0; exp_empty = 1'b0; exp_underruns = 0;
    doZero(1'b0, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired after %0d assertions", n_checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
